addr_rr_scheduler: RTL
======================

// Module: addr_rr_scheduler
// PURPOSE
//  Round-robin scheduler that shares one 8-bit pipelined adder between NUM_REQ requesters.
//  Accepts one operand set per cycle and drives it to the adder's Data_val/Value_a/Value_b/c_in.
//  Records the issuing requester in an in-order tag FIFO and routes each returned sum/carry
//  back to that requester. Sits between the client blocks and dut_8bit_addr.
// PARAMETERS
//  NUM_REQ          4  number of requesters (2..8)
//  WIDTH            8  operand/sum width; must match the adder
//  ADDR_LAT         3  adder latency, add_data_val high -> add_data_ready high (cycles)
//  MAX_OUTSTANDING  4  tag FIFO depth / issue credits, power of 2, >= ADDR_LAT+1 for full rate
// PORTS
//  clk              in   1              clock, rising edge
//  reset_n          in   1              synchronous reset, active low
//  sched_en         in   1              1 = issue permitted; 0 = stop issuing and drain
//  req_valid        in   NUM_REQ        per-requester operation request
//  req_a            in   NUM_REQ*WIDTH  operand A; slice i belongs to requester i
//  req_b            in   NUM_REQ*WIDTH  operand B; slice i belongs to requester i
//  req_cin          in   NUM_REQ        carry-in, bit i for requester i
//  req_ready        out  NUM_REQ        one-hot grant (combinational); valid&ready = accepted
//  rsp_valid        out  NUM_REQ        one-hot, 1-cycle pulse: result for requester i
//  rsp_sum          out  WIDTH          result sum, valid while any rsp_valid bit is set
//  rsp_carry        out  1              result carry-out
//  add_data_val     out  1              to adder Data_val (registered)
//  add_value_a      out  WIDTH          to adder Value_a (registered)
//  add_value_b      out  WIDTH          to adder Value_b (registered)
//  add_c_in         out  1              to adder c_in (registered)
//  add_sum_result   in   WIDTH          from adder Sum_result
//  add_sum_carry    in   1              from adder Sum_carry
//  add_data_ready   in   1              from adder Data_ready
//  sched_idle       out  1              1 in IDLE state
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge): all outputs 0 except sched_idle=1; FIFO empty; count=0;
//    RR pointer=0; state=IDLE. Reset mid-operation discards all in-flight tags.
//  FSM: IDLE  -> ACTIVE when sched_en=1.
//       ACTIVE-> DRAIN when sched_en=0 and count>0; -> IDLE when sched_en=0 and count=0.
//       DRAIN -> IDLE when count=0; -> ACTIVE when sched_en=1 (takes priority over IDLE).
//  Grant: only in ACTIVE, and only when count<MAX_OUTSTANDING or a pop occurs the same cycle.
//    Winner = first requester with req_valid, searching from RR pointer upward with wrap.
//    On a grant to i, the pointer becomes (i+1) mod NUM_REQ; with no grant it is unchanged.
//  Issue: granted operands are registered onto add_*; add_data_val=1 for exactly one cycle per grant.
//    Without a grant, add_data_val=0 and add_value_a/add_value_b/add_c_in=0.
//  Tag FIFO: push the grant index on grant; pop on add_data_ready. Simultaneous push and
//    pop leaves count unchanged. Ordering is strictly in-order.
//  Return: the cycle after add_data_ready=1, rsp_valid[popped tag]=1, with rsp_sum/rsp_carry
//    registered from the adder. rsp_sum/rsp_carry are 0 when no rsp_valid bit is set.
//  End-to-end latency: accepted in cycle T -> add_data_val in T+1 -> add_data_ready in T+4
//    -> rsp_valid in T+5.
//  Throughput: 1 op/cycle when MAX_OUTSTANDING >= ADDR_LAT+1.
//  Arithmetic is performed entirely by the adder; this block does no arithmetic on data.
//  add_data_ready while the FIFO is empty (orphan): ignored, no rsp_valid, count stays 0.
// CONFIGURATION
//  ADDR_SCHED_ERR_EN defined: extra output port sched_err (1 bit, reset 0) is added.
//    sched_err is a sticky flag set by an orphan add_data_ready or a push into a full FIFO.
//    sched_err is cleared only by reset.
//  ADDR_SCHED_ERR_EN undefined: sched_err is absent; orphans are ignored silently.
// TESTING
//  1. Single op: en=1; req0 a=8'h0F, b=8'h01, cin=0 -> req_ready[0] same cycle;
//     rsp_valid[0] at T+5; sum=8'h10, carry=0.
//  2. Carry out: req2 a=8'hFF, b=8'h00, cin=1 -> rsp_valid[2]; sum=8'h00, carry=1.
//  3. Fairness: all 4 req_valid held high for 8 cycles -> grant order 0,1,2,3,0,1,2,3;
//     8 responses in the same order, one per cycle.
//  4. Credits: MAX_OUTSTANDING=2 with continuous requests -> count never exceeds 2;
//     results still arrive in order.
//  5. Drain: en drops with 3 ops in flight -> state DRAIN, no new grants, 3 rsp pulses,
//     then sched_idle=1.
//  6. Reset mid-flight, then 1 orphan add_data_ready -> no rsp_valid;
//     sched_err=1 only with ADDR_SCHED_ERR_EN.

Source files
------------

// File: rtl/addr_rr_scheduler.sv
// Round-robin front end sharing one pipelined adder between NUM_REQ requesters; results return in order.
// Optional ADDR_SCHED_ERR_EN adds a sticky sched_err output (orphan return or push into a full tag FIFO).
module addr_rr_scheduler #(
  parameter int NUM_REQ         = 4,
  parameter int WIDTH           = 8,
  parameter int ADDR_LAT        = 3,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          sched_en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0][WIDTH-1:0] req_a,
  input  logic [NUM_REQ-1:0][WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]            req_cin,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [WIDTH-1:0]              rsp_sum,
  output logic                          rsp_carry,
  output logic                          add_data_val,
  output logic [WIDTH-1:0]              add_value_a,
  output logic [WIDTH-1:0]              add_value_b,
  output logic                          add_c_in,
  input  logic [WIDTH-1:0]              add_sum_result,
  input  logic                          add_sum_carry,
  input  logic                          add_data_ready,
`ifdef ADDR_SCHED_ERR_EN
  output logic                          sched_err,
`endif
  output logic                          sched_idle
);
  localparam int PTR_W   = $clog2(NUM_REQ);
  localparam int FIFO_AW = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W   = FIFO_AW + 1;
  localparam logic [PTR_W:0]   NREQ    = (PTR_W+1)'(NUM_REQ);
  localparam logic [CNT_W-1:0] CREDITS = CNT_W'(MAX_OUTSTANDING);

  generate
    if (NUM_REQ < 2 || NUM_REQ > 8 || ADDR_LAT < 1 || MAX_OUTSTANDING < 2 ||
        (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_cfg
      $error("addr_rr_scheduler: unsupported parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   tag_mem [MAX_OUTSTANDING];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               pop, full, can_issue, grant_any;
  logic [PTR_W-1:0]   grant_idx, head_tag;
  logic [PTR_W:0]     cand;

  assign pop       = add_data_ready && (count != '0);
  assign full      = (count == CREDITS);
  assign head_tag  = tag_mem[rd_ptr];
  // A pop in the same cycle frees the credit the new grant consumes.
  assign can_issue = reset_n && (state == S_ACTIVE) && (!full || pop);

  // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (cand >= NREQ) cand = cand - NREQ;
      if (can_issue && req_valid[cand[PTR_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_any) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (grant_any) tag_mem[wr_ptr] <= grant_idx;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      sched_idle   <= 1'b1;
      rr_ptr       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      add_data_val <= 1'b0;
      add_value_a  <= '0;
      add_value_b  <= '0;
      add_c_in     <= 1'b0;
      rsp_valid    <= '0;
      rsp_sum      <= '0;
      rsp_carry    <= 1'b0;
`ifdef ADDR_SCHED_ERR_EN
      sched_err    <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (sched_en) state <= S_ACTIVE;
          sched_idle <= !sched_en;
        end
        S_ACTIVE: begin
          if (!sched_en) state <= (count != '0) ? S_DRAIN : S_IDLE;
          sched_idle <= !sched_en && (count == '0);
        end
        S_DRAIN: begin
          if (sched_en)            state <= S_ACTIVE;
          else if (count == '0)    state <= S_IDLE;
          sched_idle <= !sched_en && (count == '0);
        end
        default: begin
          state      <= S_IDLE;
          sched_idle <= 1'b1;
        end
      endcase

      if (grant_any) begin
        rr_ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      case ({grant_any, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      add_data_val <= grant_any;
      add_value_a  <= grant_any ? req_a[grant_idx]   : '0;
      add_value_b  <= grant_any ? req_b[grant_idx]   : '0;
      add_c_in     <= grant_any ? req_cin[grant_idx] : 1'b0;

      rsp_valid <= pop ? (NUM_REQ'(1) << head_tag) : '0;
      rsp_sum   <= pop ? add_sum_result : '0;
      rsp_carry <= pop ? add_sum_carry  : 1'b0;
`ifdef ADDR_SCHED_ERR_EN
      if ((add_data_ready && count == '0) || (grant_any && full && !pop)) sched_err <= 1'b1;
`endif
    end
  end
endmodule
